// File: rtl/mexp_pkg.sv
// Shared definitions for the Montgomery exponentiation sequencer and the
// multiplier wrapper: FSM encodings, default widths and the default
// Montgomery constants.
//
// Default constants belong to the standalone modulus N2 = 2^507 + 1 with
// Montgomery radix R = 2^OP_W (OP_W = 528):
//   R mod N2   = 2^507 + 1 - 2^21   (2^507 == -1, so 2^528 == -2^21)
//   R^2 mod N2 = 2^42               (2^1014 == 1, so 2^1056 == 2^42)
// Real deployments override R_MOD/R2_MOD with the values for their own N2.
package mexp_pkg;

  localparam int M_LENGTH_DEFAULT   = 512;
  localparam int OP_W_DEFAULT       = M_LENGTH_DEFAULT + 16;
  localparam int EXP_W_DEFAULT      = 256;
  localparam int MM_TIMEOUT_DEFAULT = 64;

  localparam logic [OP_W_DEFAULT-1:0] R_MOD_DEFAULT =
    (528'd1 << 507) + 528'd1 - (528'd1 << 21);
  localparam logic [OP_W_DEFAULT-1:0] R2_MOD_DEFAULT = 528'd1 << 42;

  // Operation-level sequencing.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TO_MONT,
    ST_SQR,
    ST_MUL,
    ST_FROM_MONT,
    ST_FIN
  } op_state_t;

  // Handshake phase of the multiplier operation currently in flight.
  typedef enum logic [1:0] {
    SUB_ISSUE,
    SUB_ARM,
    SUB_WAIT
  } sub_state_t;

  // Bits needed for a counter that runs 0..n-1 (never narrower than 1).
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mont_exp_ctrl_if.sv
// Start/done handshake between the exponentiation sequencer (master) and the
// shared serial Montgomery multiplier (slave). mm_done is a level that stays
// high until the next mm_start; mm_product is valid while mm_done is high.
interface mont_exp_ctrl_if import mexp_pkg::*; #(
  parameter int OP_W = OP_W_DEFAULT
) ();

  logic            mm_start;
  logic [OP_W-1:0] mm_a;
  logic [OP_W-1:0] mm_b;
  logic            mm_done;
  logic [OP_W-1:0] mm_product;

  modport master (
    output mm_start,
    output mm_a,
    output mm_b,
    input  mm_done,
    input  mm_product
  );

  modport slave (
    input  mm_start,
    input  mm_a,
    input  mm_b,
    output mm_done,
    output mm_product
  );

endinterface

// File: rtl/mexp_bit_scanner.sv
// Exponent bit scanner: holds the exponent as a left-shifting register and
// counts consumed bits, presenting the current (MSB) bit and a flag that the
// current bit is the last one.
module mexp_bit_scanner import mexp_pkg::*; #(
  parameter int EXP_W = EXP_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             shift,
  input  logic [EXP_W-1:0] exponent,
  output logic             cur_bit,
  output logic             last_bit
);

  localparam int CNT_W = cnt_width(EXP_W);

  logic [EXP_W-1:0] exp_sh_reg;
  logic [CNT_W-1:0] bit_cnt_reg;

  // Load a fresh exponent or consume one bit, MSB first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_sh_reg  <= '0;
      bit_cnt_reg <= '0;
    end else if (load) begin
      exp_sh_reg  <= exponent;
      bit_cnt_reg <= '0;
    end else if (shift) begin
      exp_sh_reg  <= exp_sh_reg << 1;
      bit_cnt_reg <= bit_cnt_reg + 1'b1;
    end
  end

  assign cur_bit  = exp_sh_reg[EXP_W-1];
  assign last_bit = (bit_cnt_reg == CNT_W'(EXP_W - 1));

endmodule

// File: rtl/mont_exp_ctrl.sv
// Montgomery modular exponentiation sequencer: result = base^exponent mod N2
// by left-to-right square-and-multiply, driving one shared serial Montgomery
// multiplier through a start/done handshake.
// Operation order: into-domain, then per exponent bit a square and an optional
// multiply, then out-of-domain.
// Optional feature macro: MEXP_CONST_TIME_EN -- issue the multiply for every
// exponent bit and discard the unwanted products, so the operation count does
// not depend on the exponent.
module mont_exp_ctrl import mexp_pkg::*; #(
  parameter int                   M_LENGTH   = M_LENGTH_DEFAULT,
  parameter int                   EXP_W      = EXP_W_DEFAULT,
  parameter logic [M_LENGTH+15:0] R2_MOD     = R2_MOD_DEFAULT[M_LENGTH+15:0],
  parameter logic [M_LENGTH+15:0] R_MOD      = R_MOD_DEFAULT[M_LENGTH+15:0],
  parameter int                   MM_TIMEOUT = MM_TIMEOUT_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [M_LENGTH+15:0] base,
  input  logic [EXP_W-1:0]     exponent,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [M_LENGTH+15:0] result,
  mont_exp_ctrl_if.master      mm
);

  localparam int OP_W   = M_LENGTH + 16;
  localparam int WAIT_W = cnt_width(MM_TIMEOUT);
  localparam logic [OP_W-1:0] MONT_ONE_PLAIN = {{(OP_W-1){1'b0}}, 1'b1};

  op_state_t        state_reg, state_next;
  sub_state_t       sub_reg, sub_next;
  logic [OP_W-1:0]  acc_reg, acc_next;
  logic [OP_W-1:0]  base_m_reg, base_m_next;
  logic [OP_W-1:0]  base_reg, base_next;
  logic [OP_W-1:0]  result_reg, result_next;
  logic [OP_W-1:0]  mm_a_reg, mm_a_next;
  logic [OP_W-1:0]  mm_b_reg, mm_b_next;
  logic [WAIT_W-1:0] wait_cnt_reg, wait_cnt_next;
  logic             busy_reg, busy_next;
  logic             done_reg, done_next;
  logic             err_reg, err_next;
  logic             mm_start_reg, mm_start_next;
  logic [OP_W-1:0]  op_a, op_b;
  logic             scan_load, scan_shift;
  logic             cur_bit, last_bit;
`ifdef MEXP_CONST_TIME_EN
  // Sink for multiply products of 0 bits; keeps the write path symmetric.
  logic [OP_W-1:0]  dummy_reg, dummy_next;
`endif

  mexp_bit_scanner #(
    .EXP_W (EXP_W)
  ) u_scanner (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (scan_load),
    .shift    (scan_shift),
    .exponent (exponent),
    .cur_bit  (cur_bit),
    .last_bit (last_bit)
  );

  // Operand pair for the multiplier operation belonging to the current state.
  always_comb begin
    op_a = '0;
    op_b = '0;
    case (state_reg)
      ST_TO_MONT:   begin op_a = base_reg; op_b = R2_MOD;         end
      ST_SQR:       begin op_a = acc_reg;  op_b = acc_reg;        end
      ST_MUL:       begin op_a = acc_reg;  op_b = base_m_reg;     end
      ST_FROM_MONT: begin op_a = acc_reg;  op_b = MONT_ONE_PLAIN; end
      default:      ;
    endcase
  end

  // Next-state, datapath updates and registered-output values.
  always_comb begin
    state_next    = state_reg;
    sub_next      = sub_reg;
    acc_next      = acc_reg;
    base_m_next   = base_m_reg;
    base_next     = base_reg;
    result_next   = result_reg;
    mm_a_next     = mm_a_reg;
    mm_b_next     = mm_b_reg;
    wait_cnt_next = wait_cnt_reg;
    busy_next     = busy_reg;
    done_next     = 1'b0;
    err_next      = 1'b0;
    mm_start_next = 1'b0;
    scan_load     = 1'b0;
    scan_shift    = 1'b0;
`ifdef MEXP_CONST_TIME_EN
    dummy_next    = dummy_reg;
`endif

    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          base_next  = base;
          scan_load  = 1'b1;
          busy_next  = 1'b1;
          state_next = ST_TO_MONT;
          sub_next   = SUB_ISSUE;
        end
      end

      // done is high and busy low for exactly this cycle; start is not
      // sampled here, so a start coinciding with done waits for IDLE.
      ST_FIN: begin
        state_next = ST_IDLE;
      end

      default: begin
        case (sub_reg)
          SUB_ISSUE: begin
            mm_a_next     = op_a;
            mm_b_next     = op_b;
            mm_start_next = 1'b1;
            wait_cnt_next = '0;
            sub_next      = SUB_ARM;
          end

          // mm_start is on the wire now; mm_done still shows the previous op.
          SUB_ARM: begin
            wait_cnt_next = wait_cnt_reg + 1'b1;
            sub_next      = SUB_WAIT;
          end

          SUB_WAIT: begin
            if (mm.mm_done) begin
              sub_next = SUB_ISSUE;
              case (state_reg)
                ST_TO_MONT: begin
                  base_m_next = mm.mm_product;
                  acc_next    = R_MOD;
                  state_next  = ST_SQR;
                end
                ST_SQR: begin
                  acc_next = mm.mm_product;
`ifdef MEXP_CONST_TIME_EN
                  state_next = ST_MUL;
`else
                  if (cur_bit) begin
                    state_next = ST_MUL;
                  end else begin
                    scan_shift = 1'b1;
                    state_next = last_bit ? ST_FROM_MONT : ST_SQR;
                  end
`endif
                end
                ST_MUL: begin
`ifdef MEXP_CONST_TIME_EN
                  if (cur_bit) acc_next   = mm.mm_product;
                  else         dummy_next = mm.mm_product;
`else
                  acc_next = mm.mm_product;
`endif
                  scan_shift = 1'b1;
                  state_next = last_bit ? ST_FROM_MONT : ST_SQR;
                end
                ST_FROM_MONT: begin
                  result_next = mm.mm_product;
                  done_next   = 1'b1;
                  busy_next   = 1'b0;
                  state_next  = ST_FIN;
                end
                default: ;
              endcase
            end else if (wait_cnt_reg == WAIT_W'(MM_TIMEOUT - 1)) begin
              // Abandon the in-flight multiply; result keeps its old value.
              err_next   = 1'b1;
              busy_next  = 1'b0;
              state_next = ST_IDLE;
              sub_next   = SUB_ISSUE;
            end else begin
              wait_cnt_next = wait_cnt_reg + 1'b1;
            end
          end

          default: sub_next = SUB_ISSUE;
        endcase
      end
    endcase
  end

  // State and datapath registers; reset clears everything mid-operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      sub_reg      <= SUB_ISSUE;
      acc_reg      <= '0;
      base_m_reg   <= '0;
      base_reg     <= '0;
      result_reg   <= '0;
      mm_a_reg     <= '0;
      mm_b_reg     <= '0;
      wait_cnt_reg <= '0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      err_reg      <= 1'b0;
      mm_start_reg <= 1'b0;
`ifdef MEXP_CONST_TIME_EN
      dummy_reg    <= '0;
`endif
    end else begin
      state_reg    <= state_next;
      sub_reg      <= sub_next;
      acc_reg      <= acc_next;
      base_m_reg   <= base_m_next;
      base_reg     <= base_next;
      result_reg   <= result_next;
      mm_a_reg     <= mm_a_next;
      mm_b_reg     <= mm_b_next;
      wait_cnt_reg <= wait_cnt_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
      err_reg      <= err_next;
      mm_start_reg <= mm_start_next;
`ifdef MEXP_CONST_TIME_EN
      dummy_reg    <= dummy_next;
`endif
    end
  end

  assign busy        = busy_reg;
  assign done        = done_reg;
  assign err         = err_reg;
  assign result      = result_reg;
  assign mm.mm_start = mm_start_reg;
  assign mm.mm_a     = mm_a_reg;
  assign mm.mm_b     = mm_b_reg;

endmodule

// File: tb/tb_mont_exp_ctrl.sv
// Bench for mont_exp_ctrl: behavioural Montgomery multiplier (N2 = 2^47+1,
// R = 2^64, 34-cycle latency, level done), mm_start pulse counter and a
// scoreboard of expected completions.
module tb_mont_exp_ctrl;

  localparam int M_LENGTH   = 48;
  localparam int OP_W       = 64;
  localparam int EXP_W      = 256;
  localparam int MM_LAT     = 34;
  localparam int MM_TIMEOUT = 64;
  localparam int BUDGET     = 25000;

  localparam logic [63:0] N2     = 64'h0000_8000_0000_0001;
  localparam logic [63:0] R_MOD  = 64'h0000_7FFF_FFFE_0001; // 2^64 mod N2
  localparam logic [63:0] R2_MOD = 64'h0000_0004_0000_0000; // 2^128 mod N2

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [OP_W-1:0]   base = '0;
  logic [EXP_W-1:0]  exponent = '0;
  logic              busy, done, err;
  logic [OP_W-1:0]   result;

  mont_exp_ctrl_if #(.OP_W(OP_W)) mm ();

  mont_exp_ctrl #(
    .M_LENGTH   (M_LENGTH),
    .EXP_W      (EXP_W),
    .R2_MOD     (R2_MOD),
    .R_MOD      (R_MOD),
    .MM_TIMEOUT (MM_TIMEOUT)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .base     (base),
    .exponent (exponent),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .result   (result),
    .mm       (mm.master)
  );

  always #5 clk = ~clk;

  int     tests = 0;
  int     fails = 0;
  longint cyc = 0;
  int     pulses = 0;
  longint start_cyc = 0;

  typedef struct {
    logic        is_err;
    logic [63:0] value;
    int          n_ops;
    int          p0;
  } exp_t;
  exp_t sb_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // a*b*R^-1 mod N2 by REDC; N2^-1 mod 2^64 from Newton iteration.
  function automatic logic [63:0] mont(input logic [63:0] a, input logic [63:0] b);
    logic [63:0]  inv, m;
    logic [127:0] t;
    logic [128:0] u;
    inv = 64'd1;
    for (int i = 0; i < 6; i++) inv = inv * (64'd2 - N2 * inv);
    t = {64'd0, a} * {64'd0, b};
    m = t[63:0] * (64'd0 - inv);
    u = ({1'b0, t} + {65'd0, m} * {65'd0, N2}) >> 64;
    if (u >= {65'd0, N2}) u = u - {65'd0, N2};
    return u[63:0];
  endfunction

  // Multiplier model; with hang set it accepts mm_start but never finishes.
  logic        hang = 1'b0;
  logic [63:0] cap_a = '0, cap_b = '0;
  int          lat = 0;
  logic        inflight = 1'b0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mm.mm_done    <= 1'b0;
      mm.mm_product <= '0;
      inflight      <= 1'b0;
      lat           <= 0;
    end else if (mm.mm_start) begin
      mm.mm_done <= 1'b0;
      cap_a      <= mm.mm_a;
      cap_b      <= mm.mm_b;
      inflight   <= !hang;
      lat        <= MM_LAT;
    end else if (inflight) begin
      if (lat > 1) lat <= lat - 1;
      else begin
        mm.mm_done    <= 1'b1;
        mm.mm_product <= mont(cap_a, cap_b);
        inflight      <= 1'b0;
      end
    end
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mm.mm_start === 1'b1) begin
      pulses    <= pulses + 1;
      start_cyc <= cyc;
    end
  end

  // Scoreboard pop on done/err; operand stability per multiplier op.
  logic stab_bad = 1'b0;
  logic prev_done = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && (done || err)) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_completion", {62'd0, done, err}, 64'd0);
      end else begin
        e = sb_q.pop_front();
        chk("err_flag", {63'd0, err}, {63'd0, e.is_err});
        chk("done_flag", {63'd0, done}, {63'd0, !e.is_err});
        chk("result", result, e.value);
        chk("busy_at_end", {63'd0, busy}, 64'd0);
        chk("mm_start_count", 64'(pulses - e.p0), 64'(e.n_ops));
        if (e.is_err) chk("err_latency", 64'(cyc - start_cyc), 64'd64);
      end
    end
    if (mm.mm_start) stab_bad <= 1'b0;
    else if (inflight && (mm.mm_a !== cap_a || mm.mm_b !== cap_b)) stab_bad <= 1'b1;
    if (mm.mm_done && !prev_done) chk("operand_stable", {63'd0, stab_bad}, 64'd0);
    prev_done <= mm.mm_done;
  end

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
    chk({tag, "_done"}, {63'd0, done}, 64'd0);
    chk({tag, "_err"}, {63'd0, err}, 64'd0);
    chk({tag, "_result"}, result, 64'd0);
    chk({tag, "_mm_start"}, {63'd0, mm.mm_start}, 64'd0);
    chk({tag, "_mm_a"}, mm.mm_a, 64'd0);
    chk({tag, "_mm_b"}, mm.mm_b, 64'd0);
  endtask

  task automatic issue(input logic [63:0] b, input logic [EXP_W-1:0] e,
                       input logic is_err, input logic [63:0] value);
    exp_t x;
    int   n;
`ifdef MEXP_CONST_TIME_EN
    n = 2 + 2 * EXP_W;
`else
    n = 2 + EXP_W + $countones(e);
`endif
    if (is_err) n = 1;
    @(posedge clk); #1;
    start    = 1'b1;
    base     = b;
    exponent = e;
    x = '{is_err, value, n, pulses};
    sb_q.push_back(x);
    @(posedge clk); #1;
    start    = 1'b0;
    base     = '0;
    exponent = '0;
    chk("busy_after_start", {63'd0, busy}, 64'd1);
  endtask

  task automatic wait_end(input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < BUDGET; i++) begin
      @(negedge clk);
      if (done || err) begin
        seen = 1'b1;
        break;
      end
    end
    chk({tag, "_completed"}, {63'd0, seen}, 64'd1);
    @(negedge clk);
    chk({tag, "_pulse_one_cycle"}, {62'd0, done, err}, 64'd0);
    chk({tag, "_idle_busy"}, {63'd0, busy}, 64'd0);
  endtask

  initial begin
    @(posedge clk); #1;
    check_outputs_zero("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // base=2 exp=10, with a second start (base=7) while busy that must be ignored
    issue(64'd2, 256'd10, 1'b0, 64'd1024);
    repeat (50) @(posedge clk);
    #1;
    start = 1'b1; base = 64'd7; exponent = 256'd3;
    @(posedge clk); #1;
    start = 1'b0; base = '0; exponent = '0;
    wait_end("exp10");

    issue(64'd5, 256'd0, 1'b0, 64'd1);
    wait_end("exp0");

    issue(64'd5, 256'd1, 1'b0, 64'd5);
    wait_end("exp1");

    // multiplier never answers: err, result keeps the previous value
    hang = 1'b1;
    issue(64'd9, 256'd5, 1'b1, 64'd5);
    wait_end("timeout");
    hang = 1'b0;

    // asynchronous reset in the middle of an operation
    issue(64'd6, 256'd7, 1'b0, 64'd0);
    repeat (100) @(posedge clk);
    #2 rst_n = 1'b0;
    sb_q.delete();
    #1 check_outputs_zero("midop_reset");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);

    issue(64'd3, 256'd4, 1'b0, 64'd81);
    wait_end("after_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
